// File: rtl/ctrl_arbiter.sv
// ctrl_arbiter: debounces per-channel controller buttons on the game tick,
// hands control to the lowest-index connected channel that shows a new press,
// and turns that channel's presses into a start pulse and one latched turn
// request that lives until acknowledged, replaced, expired or disconnected.
module ctrl_arbiter #(
    parameter int NUM_CTRL   = 2,
    parameter int DEBOUNCE   = 2,
    parameter int HOLD_TICKS = 15,
    localparam int SEL_W     = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [NUM_CTRL-1:0] ctrl_valid,
    input  logic [NUM_CTRL-1:0] ctrl_start,
    input  logic [NUM_CTRL-1:0] ctrl_left,
    input  logic [NUM_CTRL-1:0] ctrl_right,
    input  logic [NUM_CTRL-1:0] ctrl_uturn,
    input  logic                turn_ack,
    output logic                start,
    output logic                lturn,
    output logic                rturn,
    output logic                uturn,
    output logic [SEL_W-1:0]    sel,
    output logic                sel_valid
);

    localparam int CNT_W   = 3;
    localparam int B_START = 0;
    localparam int B_LEFT  = 1;
    localparam int B_RIGHT = 2;
    localparam int B_UTURN = 3;

    // Button bundle per channel: {uturn, right, left, start}
    logic [3:0]       raw  [NUM_CTRL];
    logic [3:0]       deb  [NUM_CTRL];
    logic [CNT_W-1:0] cnt  [NUM_CTRL][4];
    logic [3:0]       hit  [NUM_CTRL];
    logic [3:0]       rise [NUM_CTRL];

    logic             cand_found;
    logic [SEL_W-1:0] cand_idx;
    logic [3:0]       cand_rise;
    logic             sel_conn;

    logic [7:0]       hold;
    logic [7:0]       hold_nxt;
    logic [2:0]       turn_nxt;   // {uturn, rturn, lturn}
    logic             start_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic             selv_nxt;

    // Gather raw buttons and find which counters complete their agree run this tick
    always_comb begin
        for (int c = 0; c < NUM_CTRL; c++) begin
            raw[c] = {ctrl_uturn[c], ctrl_right[c], ctrl_left[c], ctrl_start[c]};
            for (int b = 0; b < 4; b++) begin
                hit[c][b]  = (raw[c][b] != deb[c][b]) &&
                             (cnt[c][b] == CNT_W'(DEBOUNCE - 1));
                rise[c][b] = tick && hit[c][b] && raw[c][b];
            end
        end
    end

    // Debounced levels and agree-counters advance only on ticks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CTRL; c++) begin
                deb[c] <= '0;
                for (int b = 0; b < 4; b++) begin
                    cnt[c][b] <= '0;
                end
            end
        end else if (tick) begin
            for (int c = 0; c < NUM_CTRL; c++) begin
                for (int b = 0; b < 4; b++) begin
                    if (raw[c][b] != deb[c][b]) begin
                        if (hit[c][b]) begin
                            deb[c][b] <= raw[c][b];
                            cnt[c][b] <= '0;
                        end else begin
                            cnt[c][b] <= cnt[c][b] + 3'd1;
                        end
                    end else begin
                        cnt[c][b] <= '0;
                    end
                end
            end
        end
    end

    // Lowest-index connected channel with a fresh edge, and whether sel is still connected
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        cand_rise  = '0;
        sel_conn   = 1'b0;
        for (int c = NUM_CTRL - 1; c >= 0; c--) begin
            if (ctrl_valid[c] && (rise[c] != 4'b0000)) begin
                cand_found = 1'b1;
                cand_idx   = SEL_W'(c);
                cand_rise  = rise[c];
            end
        end
        for (int c = 0; c < NUM_CTRL; c++) begin
            if (SEL_W'(c) == sel) begin
                sel_conn = ctrl_valid[c];
            end
        end
    end

    // Next selection, start pulse and pending-turn state
    always_comb begin
        start_nxt = 1'b0;
        sel_nxt   = sel;
        selv_nxt  = sel_valid;
        turn_nxt  = {uturn, rturn, lturn};
        hold_nxt  = hold;

        // Losing the active controller drops its pending turn, sel stays put
        if (sel_valid && !sel_conn) begin
            selv_nxt = 1'b0;
            turn_nxt = 3'b000;
            hold_nxt = '0;
        end

        // A new owner starts from a clean turn state before its own edge lands
        if (cand_found) begin
            if (cand_idx != sel) begin
                turn_nxt = 3'b000;
                hold_nxt = '0;
            end
            sel_nxt   = cand_idx;
            selv_nxt  = 1'b1;
            start_nxt = cand_rise[B_START];
        end

        if (cand_found && (cand_rise[B_UTURN] || cand_rise[B_LEFT] || cand_rise[B_RIGHT])) begin
            hold_nxt = '0;
            if (cand_rise[B_UTURN]) begin
                turn_nxt = 3'b100;
            end else if (cand_rise[B_LEFT]) begin
                turn_nxt = 3'b001;
            end else begin
                turn_nxt = 3'b010;
            end
        end else if (turn_nxt != 3'b000) begin
            if (turn_ack) begin
                turn_nxt = 3'b000;
                hold_nxt = '0;
            end else if (tick) begin
                if (hold == 8'(HOLD_TICKS - 1)) begin
                    turn_nxt = 3'b000;
                    hold_nxt = '0;
                end else begin
                    hold_nxt = hold + 8'd1;
                end
            end
        end
    end

    // Registered outputs and hold counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start     <= 1'b0;
            lturn     <= 1'b0;
            rturn     <= 1'b0;
            uturn     <= 1'b0;
            sel       <= '0;
            sel_valid <= 1'b0;
            hold      <= '0;
        end else begin
            start     <= start_nxt;
            lturn     <= turn_nxt[0];
            rturn     <= turn_nxt[1];
            uturn     <= turn_nxt[2];
            sel       <= sel_nxt;
            sel_valid <= selv_nxt;
            hold      <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_ctrl_arbiter.sv
// Bench for ctrl_arbiter: directed scenarios against hand-derived values,
// then randomized traffic against a behavioural model of the arbiter rules.
module tb_ctrl_arbiter;

    localparam int NUM  = 2;
    localparam int DEB  = 2;
    localparam int HOLD = 15;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           tick = 1'b0;
    logic [NUM-1:0] ctrl_valid = '0;
    logic [NUM-1:0] ctrl_start = '0;
    logic [NUM-1:0] ctrl_left  = '0;
    logic [NUM-1:0] ctrl_right = '0;
    logic [NUM-1:0] ctrl_uturn = '0;
    logic           turn_ack = 1'b0;
    logic           start;
    logic           lturn;
    logic           rturn;
    logic           uturn;
    logic [0:0]     sel;
    logic           sel_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model state: run length of differing samples, debounced
    // level, turn code (0 none, 1 left, 2 right, 3 uturn), ticks left.
    int m_run [NUM][4];
    bit m_deb [NUM][4];
    bit m_start;
    int m_turn;
    int m_sel;
    bit m_selv;
    int m_left;

    ctrl_arbiter #(.NUM_CTRL(NUM), .DEBOUNCE(DEB), .HOLD_TICKS(HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .ctrl_valid (ctrl_valid),
        .ctrl_start (ctrl_start),
        .ctrl_left  (ctrl_left),
        .ctrl_right (ctrl_right),
        .ctrl_uturn (ctrl_uturn),
        .turn_ack   (turn_ack),
        .start      (start),
        .lturn      (lturn),
        .rturn      (rturn),
        .uturn      (uturn),
        .sel        (sel),
        .sel_valid  (sel_valid)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit [3:0] raw;
        bit [3:0] rise [NUM];
        int cand;
        bit n_start;
        if (!rst) begin
            for (int c = 0; c < NUM; c++)
                for (int b = 0; b < 4; b++) begin
                    m_run[c][b] = 0;
                    m_deb[c][b] = 1'b0;
                end
            m_start = 1'b0; m_turn = 0; m_sel = 0; m_selv = 1'b0; m_left = 0;
            return;
        end
        n_start = 1'b0;
        cand = -1;
        if (m_selv && !ctrl_valid[m_sel]) begin
            m_selv = 1'b0;
            m_turn = 0;
        end
        for (int c = 0; c < NUM; c++) rise[c] = 4'b0000;
        if (tick) begin
            for (int c = 0; c < NUM; c++) begin
                raw = {ctrl_uturn[c], ctrl_right[c], ctrl_left[c], ctrl_start[c]};
                for (int b = 0; b < 4; b++) begin
                    if (raw[b] != m_deb[c][b]) begin
                        m_run[c][b]++;
                        if (m_run[c][b] >= DEB) begin
                            m_deb[c][b] = raw[b];
                            m_run[c][b] = 0;
                            rise[c][b]  = raw[b];
                        end
                    end else begin
                        m_run[c][b] = 0;
                    end
                end
            end
            for (int c = 0; c < NUM; c++)
                if (cand < 0 && ctrl_valid[c] && rise[c] != 4'b0000) cand = c;
        end
        if (cand >= 0) begin
            if (cand != m_sel) m_turn = 0;
            m_sel   = cand;
            m_selv  = 1'b1;
            n_start = rise[cand][0];
        end
        if (cand >= 0 && rise[cand][3]) begin
            m_turn = 3; m_left = HOLD;
        end else if (cand >= 0 && rise[cand][1]) begin
            m_turn = 1; m_left = HOLD;
        end else if (cand >= 0 && rise[cand][2]) begin
            m_turn = 2; m_left = HOLD;
        end else if (m_turn != 0) begin
            if (turn_ack) begin
                m_turn = 0;
            end else if (tick) begin
                m_left--;
                if (m_left == 0) m_turn = 0;
            end
        end
        m_start = n_start;
    endtask

    // One clock: the model consumes the inputs seen at this edge, outputs settle by +1
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cycle();
        cycle();
        checks++;
        if ({start, lturn, rturn, uturn, sel_valid, sel} !== 6'b0) begin
            failures++;
            $display("FAIL reset_hold outputs=%b expected=000000", {start, lturn, rturn, uturn, sel_valid, sel});
        end
        rst = 1'b1;
        cycle();
        do_tick();
        checks++;
        if ({start, lturn, rturn, uturn, sel_valid, sel} !== 6'b0) begin
            failures++;
            $display("FAIL reset_release outputs=%b expected=000000", {start, lturn, rturn, uturn, sel_valid, sel});
        end
    endtask

    task automatic test_debounce();
        ctrl_valid = 2'b11;
        ctrl_left[0] = 1'b1;
        do_tick();
        ctrl_left[0] = 1'b0;
        do_tick();
        checks++;
        if (lturn !== 1'b0) begin
            failures++;
            $display("FAIL debounce_short lturn=%b expected=0", lturn);
        end
        ctrl_left[0] = 1'b1;
        do_tick();
        checks++;
        if (lturn !== 1'b0) begin
            failures++;
            $display("FAIL debounce_first_tick lturn=%b expected=0", lturn);
        end
        do_tick();
        checks++;
        if ({lturn, rturn, uturn, sel_valid, sel, start} !== 6'b100100) begin
            failures++;
            $display("FAIL debounce_accept l/r/u/selv/sel/start=%b expected=100100",
                     {lturn, rturn, uturn, sel_valid, sel, start});
        end
        ctrl_left[0] = 1'b0;
        do_tick();
        do_tick();
        turn_ack = 1'b1;
        cycle();
        turn_ack = 1'b0;
        checks++;
        if (lturn !== 1'b0) begin
            failures++;
            $display("FAIL ack_clear lturn=%b expected=0", lturn);
        end
    endtask

    task automatic test_selection();
        ctrl_start = 2'b11;
        do_tick();
        checks++;
        if (start !== 1'b0) begin
            failures++;
            $display("FAIL start_early start=%b expected=0", start);
        end
        do_tick();
        checks++;
        if ({start, sel_valid, sel} !== 3'b110) begin
            failures++;
            $display("FAIL select_low start/selv/sel=%b expected=110", {start, sel_valid, sel});
        end
        cycle();
        checks++;
        if (start !== 1'b0) begin
            failures++;
            $display("FAIL start_width start=%b expected=0", start);
        end
        ctrl_start = 2'b00;
        do_tick();
        do_tick();
        ctrl_right[1] = 1'b1;
        do_tick();
        checks++;
        if ({rturn, sel} !== 2'b00) begin
            failures++;
            $display("FAIL right_early rturn/sel=%b expected=00", {rturn, sel});
        end
        do_tick();
        checks++;
        if ({sel, sel_valid, rturn, lturn, start} !== 5'b11100) begin
            failures++;
            $display("FAIL select_ch1 sel/selv/rturn/lturn/start=%b expected=11100",
                     {sel, sel_valid, rturn, lturn, start});
        end
        ctrl_right[1] = 1'b0;
        do_tick();
        do_tick();
        turn_ack = 1'b1;
        cycle();
        turn_ack = 1'b0;
    endtask

    task automatic test_priority_expiry();
        ctrl_uturn[1] = 1'b1;
        ctrl_left[1]  = 1'b1;
        do_tick();
        do_tick();
        checks++;
        if ({uturn, lturn, rturn, sel} !== 4'b1001) begin
            failures++;
            $display("FAIL turn_priority u/l/r/sel=%b expected=1001", {uturn, lturn, rturn, sel});
        end
        for (int i = 0; i < HOLD - 1; i++) begin
            cycle();
            do_tick();
        end
        checks++;
        if (uturn !== 1'b1) begin
            failures++;
            $display("FAIL hold_alive uturn=%b expected=1", uturn);
        end
        do_tick();
        checks++;
        if (uturn !== 1'b0) begin
            failures++;
            $display("FAIL hold_expire uturn=%b expected=0", uturn);
        end
        ctrl_uturn[1] = 1'b0;
        ctrl_left[1]  = 1'b0;
        do_tick();
        do_tick();
    endtask

    task automatic test_ack_race();
        ctrl_left[1] = 1'b1;
        do_tick();
        do_tick();
        ctrl_right[1] = 1'b1;
        do_tick();
        checks++;
        if ({lturn, rturn} !== 2'b10) begin
            failures++;
            $display("FAIL race_setup l/r=%b expected=10", {lturn, rturn});
        end
        tick = 1'b1;
        turn_ack = 1'b1;
        cycle();
        tick = 1'b0;
        turn_ack = 1'b0;
        checks++;
        if ({lturn, rturn, uturn} !== 3'b010) begin
            failures++;
            $display("FAIL ack_race l/r/u=%b expected=010", {lturn, rturn, uturn});
        end
        ctrl_left[1]  = 1'b0;
        ctrl_right[1] = 1'b0;
        do_tick();
        do_tick();
    endtask

    task automatic test_disconnect();
        ctrl_valid = 2'b01;
        cycle();
        checks++;
        if ({rturn, sel_valid, sel} !== 3'b001) begin
            failures++;
            $display("FAIL disconnect rturn/selv/sel=%b expected=001", {rturn, sel_valid, sel});
        end
        ctrl_valid = 2'b11;
        do_tick();
        checks++;
        if (sel_valid !== 1'b0) begin
            failures++;
            $display("FAIL reconnect_noedge selv=%b expected=0", sel_valid);
        end
    endtask

    task automatic test_reset_mid();
        ctrl_uturn[1] = 1'b1;
        do_tick();
        do_tick();
        checks++;
        if ({uturn, sel_valid, sel} !== 3'b111) begin
            failures++;
            $display("FAIL mid_setup u/selv/sel=%b expected=111", {uturn, sel_valid, sel});
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({start, lturn, rturn, uturn, sel_valid, sel} !== 6'b0) begin
            failures++;
            $display("FAIL async_reset outputs=%b expected=000000", {start, lturn, rturn, uturn, sel_valid, sel});
        end
        cycle();
        rst = 1'b1;
        cycle();
        do_tick();
        checks++;
        if (uturn !== 1'b0) begin
            failures++;
            $display("FAIL held_early uturn=%b expected=0", uturn);
        end
        do_tick();
        checks++;
        if ({uturn, sel_valid, sel} !== 3'b111) begin
            failures++;
            $display("FAIL held_debounced u/selv/sel=%b expected=111", {uturn, sel_valid, sel});
        end
        ctrl_uturn[1] = 1'b0;
        do_tick();
        do_tick();
    endtask

    task automatic test_random();
        logic [5:0] exp_o;
        logic [5:0] got_o;
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NUM; c++) begin
                if ($urandom_range(15, 0) == 0) ctrl_valid[c] = ~ctrl_valid[c];
                if ($urandom_range(4, 0) == 0)  ctrl_start[c] = ~ctrl_start[c];
                if ($urandom_range(4, 0) == 0)  ctrl_left[c]  = ~ctrl_left[c];
                if ($urandom_range(4, 0) == 0)  ctrl_right[c] = ~ctrl_right[c];
                if ($urandom_range(5, 0) == 0)  ctrl_uturn[c] = ~ctrl_uturn[c];
            end
            tick     = ($urandom_range(1, 0) == 0);
            turn_ack = ($urandom_range(9, 0) == 0);
            cycle();
            exp_o = {m_start, m_turn == 1, m_turn == 2, m_turn == 3, m_selv, m_sel[0]};
            got_o = {start, lturn, rturn, uturn, sel_valid, sel};
            checks++;
            if (got_o !== exp_o) begin
                failures++;
                $display("FAIL random cycle=%0d start/l/r/u/selv/sel=%b expected=%b", n, got_o, exp_o);
            end
        end
        tick = 1'b0;
        turn_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_selection();
        test_priority_expiry();
        test_ack_race();
        test_disconnect();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
